// File: rtl/dataframe_stream_arbiter_pkg.sv
// Shared types and helpers for the dataframe stream arbiter and later schedulers.
// RFDC_TDATA_WIDTH normally comes from the common defines include; the fallback keeps this file standalone.
`ifndef RFDC_TDATA_WIDTH
`define RFDC_TDATA_WIDTH 32
`endif

package dataframe_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSFER = 2'd1,
        DRAIN    = 2'd2
    } arb_state_t;

    localparam int TDATA_W     = `RFDC_TDATA_WIDTH;
    localparam int STALL_CNT_W = 16;

    function automatic int tid_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dataframe_stream_arbiter_if.sv
// CHANNEL_NUM AXI-Stream sources in, one merged AXI-Stream out.
// master = the arbiter, slave = the surrounding generators and DMA side.
interface dataframe_stream_arbiter_if
    import dataframe_arbiter_pkg::*;
#(
    parameter int CHANNEL_NUM = 8,
    parameter int DATA_W      = TDATA_W
);
    localparam int TID_W = tid_width(CHANNEL_NUM);

    // Packed per-channel slices: channel i lives at bits [i*DATA_W +: DATA_W].
    logic [CHANNEL_NUM-1:0][DATA_W-1:0] S_AXIS_TDATA;
    logic [CHANNEL_NUM-1:0]             S_AXIS_TVALID;
    logic [CHANNEL_NUM-1:0]             S_AXIS_TLAST;
    logic [CHANNEL_NUM-1:0]             S_AXIS_TREADY;
    logic [DATA_W-1:0]                  M_AXIS_TDATA;
    logic                               M_AXIS_TVALID;
    logic                               M_AXIS_TLAST;
    logic [TID_W-1:0]                   M_AXIS_TID;
    logic                               M_AXIS_TREADY;
    logic                               ARBITER_ERROR;

    modport master (
        input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
        output S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
               M_AXIS_TID, ARBITER_ERROR
    );

    modport slave (
        output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
        input  S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
               M_AXIS_TID, ARBITER_ERROR
    );

endinterface

// File: rtl/dataframe_stream_arbiter_picker.sv
// Round-robin picker: first asserted request scanning upward from last_i+1, wrapping.
// Purely combinational so other schedulers can reuse it.
module rr_priority_picker #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from far to near so the nearest requester overwrites the rest.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int off = N; off >= 1; off--) begin
            cand = IDX_W'((int'(last_i) + off) % N);
            if (req_i[cand]) begin
                idx_o = cand;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dataframe_stream_arbiter.sv
// Frame-level round-robin merge of CHANNEL_NUM AXI-Streams; grant held from first beat to TLAST.
// Define DATAFRAME_ARBITER_WATCHDOG_EN to abort frames whose source stalls for TIMEOUT_CYCLES.
module dataframe_stream_arbiter
    import dataframe_arbiter_pkg::*;
#(
    parameter int CHANNEL_NUM    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    dataframe_stream_arbiter_if.master bus
);

    localparam int TID_W = tid_width(CHANNEL_NUM);

    if (CHANNEL_NUM < 2 || CHANNEL_NUM > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
        $error("dataframe_stream_arbiter: parameter out of range");
    end

    arb_state_t       state_q;
    logic [TID_W-1:0] grant_q;
    logic [TID_W-1:0] last_grant_q;
    logic [TID_W-1:0] pick_idx;
    logic             pick_vld;
    logic             src_vld;
    logic             src_last;
    logic             forced;

    assign src_vld  = bus.S_AXIS_TVALID[grant_q];
    assign src_last = bus.S_AXIS_TLAST[grant_q];

    rr_priority_picker #(
        .N     (CHANNEL_NUM),
        .IDX_W (TID_W)
    ) u_pick (
        .req_i  (bus.S_AXIS_TVALID),
        .last_i (last_grant_q),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

`ifdef DATAFRAME_ARBITER_WATCHDOG_EN
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   err_q;

    // Once the limit is hit the counter freezes and the forced TLAST beat is shown.
    assign forced            = (state_q == TRANSFER) && (stall_q == STALL_CNT_W'(TIMEOUT_CYCLES));
    assign bus.ARBITER_ERROR = err_q;
`else
    assign forced            = 1'b0;
    assign bus.ARBITER_ERROR = 1'b0;
`endif

    // Zero-latency pass-through; data is forced to 0 whenever nothing valid is shown.
    always_comb begin
        bus.S_AXIS_TREADY = '0;
        bus.M_AXIS_TVALID = 1'b0;
        bus.M_AXIS_TLAST  = 1'b0;
        bus.M_AXIS_TDATA  = '0;
        bus.M_AXIS_TID    = '0;
        case (state_q)
            TRANSFER: begin
                bus.M_AXIS_TID = grant_q;
                if (forced) begin
                    bus.M_AXIS_TVALID = 1'b1;
                    bus.M_AXIS_TLAST  = 1'b1;
                end else begin
                    bus.M_AXIS_TVALID         = src_vld;
                    bus.M_AXIS_TLAST          = src_vld & src_last;
                    bus.M_AXIS_TDATA          = src_vld ? bus.S_AXIS_TDATA[grant_q] : '0;
                    bus.S_AXIS_TREADY[grant_q] = bus.M_AXIS_TREADY;
                end
            end
            DRAIN: bus.S_AXIS_TREADY[grant_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= TID_W'(CHANNEL_NUM - 1);
`ifdef DATAFRAME_ARBITER_WATCHDOG_EN
            stall_q      <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_idx;
                        state_q <= TRANSFER;
`ifdef DATAFRAME_ARBITER_WATCHDOG_EN
                        stall_q <= '0;
`endif
                    end
                end
                TRANSFER: begin
`ifdef DATAFRAME_ARBITER_WATCHDOG_EN
                    if (forced) begin
                        if (bus.M_AXIS_TREADY) begin
                            err_q   <= 1'b1;
                            stall_q <= '0;
                            state_q <= DRAIN;
                        end
                    end else if (src_vld && bus.M_AXIS_TREADY) begin
                        stall_q <= '0;
                        if (src_last) begin
                            last_grant_q <= grant_q;
                            state_q      <= IDLE;
                        end
                    end else if (!src_vld) begin
                        stall_q <= stall_q + 1'b1;
                    end
`else
                    if (src_vld && bus.M_AXIS_TREADY && src_last) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
`endif
                end
`ifdef DATAFRAME_ARBITER_WATCHDOG_EN
                DRAIN: begin
                    // Swallow the rest of the aborted frame so the source realigns on its TLAST.
                    if (src_vld && src_last) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dataframe_stream_arbiter.sv
// Directed bench: per-channel source queues feed the arbiter, a scoreboard predicts merged beats.
module tb_dataframe_stream_arbiter;
    import dataframe_arbiter_pkg::*;

    localparam int N  = 8;
    localparam int W  = TDATA_W;
    localparam int TW = tid_width(N);

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [TW-1:0] tid;
        logic [W-1:0]  data;
        logic          last;
    } exp_t;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    dataframe_stream_arbiter_if #(.CHANNEL_NUM(N), .DATA_W(W)) bus ();

    dataframe_stream_arbiter #(
        .CHANNEL_NUM    (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    beat_t src_q[N][$];
    exp_t  sb[$];

    int pass_cnt   = 0;
    int chk_cnt    = 0;
    int mirror_ch  = -1;
    int idle_run   = 0;
    int gap_before = 0;
    bit toggle_rdy = 1'b0;
    bit strict_gap = 1'b0;
    bit prev_last  = 1'b0;
    bit bubble_pend = 1'b0;
    logic          samp_v;
    logic [TW-1:0] samp_tid;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    function automatic logic [W-1:0] mk(input int ch, input int f, input int b);
        return W'(ch * 65536 + f * 256 + b + 1);
    endfunction

    task automatic drive();
        for (int ch = 0; ch < N; ch++) begin
            if (src_q[ch].size() > 0) begin
                bus.S_AXIS_TVALID[ch] = 1'b1;
                bus.S_AXIS_TDATA[ch]  = src_q[ch][0].data;
                bus.S_AXIS_TLAST[ch]  = src_q[ch][0].last;
            end else begin
                bus.S_AXIS_TVALID[ch] = 1'b0;
                bus.S_AXIS_TDATA[ch]  = '0;
                bus.S_AXIS_TLAST[ch]  = 1'b0;
            end
        end
    endtask

    task automatic load_frame(input int ch, input int f, input int len, input bit expect_it);
        for (int b = 0; b < len; b++) begin
            src_q[ch].push_back('{data: mk(ch, f, b), last: (b == len - 1)});
            if (expect_it) sb.push_back('{tid: TW'(ch), data: mk(ch, f, b), last: (b == len - 1)});
        end
    endtask

    task automatic expect_frame(input int ch, input int f, input int len);
        for (int b = 0; b < len; b++)
            sb.push_back('{tid: TW'(ch), data: mk(ch, f, b), last: (b == len - 1)});
    endtask

    // Sample on the falling edge, update sources just after the rising edge.
    task automatic tick();
        logic [N-1:0] s_hs;
        exp_t e;
        @(negedge ACLK);
        samp_v   = bus.M_AXIS_TVALID;
        samp_tid = bus.M_AXIS_TID;
        if (bubble_pend) begin
            check("bubble", bus.M_AXIS_TVALID, 0);
            bubble_pend = 1'b0;
        end
        if (mirror_ch >= 0 && bus.M_AXIS_TVALID)
            check("tready_mirror", bus.S_AXIS_TREADY[mirror_ch], bus.M_AXIS_TREADY);
        if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
            check("beat_expected", 128'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("tid", bus.M_AXIS_TID, e.tid);
                check("data", bus.M_AXIS_TDATA, e.data);
                check("last", bus.M_AXIS_TLAST, e.last);
            end
            if (strict_gap && prev_last) check("frame_gap", idle_run, 1);
            gap_before  = idle_run;
            idle_run    = 0;
            prev_last   = bus.M_AXIS_TLAST;
            bubble_pend = bus.M_AXIS_TLAST;
        end else if (!bus.M_AXIS_TVALID) begin
            idle_run++;
        end
        s_hs = bus.S_AXIS_TVALID & bus.S_AXIS_TREADY;
        @(posedge ACLK);
        #1;
        for (int ch = 0; ch < N; ch++)
            if (s_hs[ch] && src_q[ch].size() > 0) void'(src_q[ch].pop_front());
        if (toggle_rdy) bus.M_AXIS_TREADY = ~bus.M_AXIS_TREADY;
        drive();
    endtask

    task automatic run_until_empty(input string name, input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done"}, sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_tvalid"}, bus.M_AXIS_TVALID, 0);
        check({name, "_tlast"}, bus.M_AXIS_TLAST, 0);
        check({name, "_tdata"}, bus.M_AXIS_TDATA, 0);
        check({name, "_tid"}, bus.M_AXIS_TID, 0);
        check({name, "_s_tready"}, bus.S_AXIS_TREADY, 0);
        check({name, "_error"}, bus.ARBITER_ERROR, 0);
    endtask

    initial begin
        bus.M_AXIS_TREADY = 1'b1;
        drive();
        repeat (2) @(posedge ACLK);
        #1;
        check_reset_outputs("rst");
        ARESETN = 1'b1;
        tick();
        check_reset_outputs("idle");

        // Channel 0, 3 beats: one cycle of arbitration before the first beat.
        load_frame(0, 1, 3, 1'b1);
        drive();
        tick();
        check("lat_idle_valid", samp_v, 0);
        tick();
        check("lat_first_valid", samp_v, 1);
        check("lat_first_tid", samp_tid, 0);
        run_until_empty("ch0", 20);

        // Channels 1, 3, 5 request together after channel 0 was served.
        strict_gap = 1'b1;
        prev_last  = 1'b0;
        load_frame(1, 2, 4, 1'b1);
        load_frame(3, 3, 4, 1'b1);
        load_frame(5, 4, 4, 1'b1);
        drive();
        run_until_empty("rr135", 40);

        // Channel 2 streams back-to-back; channel 6 joins mid-frame and goes next.
        tick();
        prev_last = 1'b0;
        load_frame(2, 10, 3, 1'b0);
        load_frame(2, 11, 3, 1'b0);
        load_frame(2, 12, 3, 1'b0);
        expect_frame(2, 10, 3);
        expect_frame(6, 20, 2);
        expect_frame(2, 11, 3);
        expect_frame(2, 12, 3);
        drive();
        tick();
        tick();
        load_frame(6, 20, 2, 1'b0);
        drive();
        run_until_empty("starve", 60);
        strict_gap = 1'b0;

        // Channel 4, 8 beats under a toggling downstream ready.
        mirror_ch  = 4;
        toggle_rdy = 1'b1;
        load_frame(4, 30, 8, 1'b1);
        drive();
        run_until_empty("bp", 60);
        toggle_rdy = 1'b0;
        mirror_ch  = -1;
        bus.M_AXIS_TREADY = 1'b1;
        tick();

        // Reset mid-frame on channel 3; afterwards channel 0 beats channel 5.
        load_frame(3, 40, 6, 1'b1);
        drive();
        repeat (3) tick();
        ARESETN = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int ch = 0; ch < N; ch++) src_q[ch].delete();
        sb.delete();
        bubble_pend = 1'b0;
        drive();
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        load_frame(5, 50, 2, 1'b0);
        load_frame(0, 51, 2, 1'b0);
        expect_frame(0, 51, 2);
        expect_frame(5, 50, 2);
        drive();
        run_until_empty("postrst", 30);
        tick();

`ifdef DATAFRAME_ARBITER_WATCHDOG_EN
        // Channel 7 stalls after two beats: forced zero TLAST beat, then drain.
        src_q[7].push_back('{data: mk(7, 60, 0), last: 1'b0});
        src_q[7].push_back('{data: mk(7, 60, 1), last: 1'b0});
        sb.push_back('{tid: TW'(7), data: mk(7, 60, 0), last: 1'b0});
        sb.push_back('{tid: TW'(7), data: mk(7, 60, 1), last: 1'b0});
        sb.push_back('{tid: TW'(7), data: '0, last: 1'b1});
        drive();
        run_until_empty("wd_abort", 60);
        check("wd_stall_gap", gap_before, 16);
        check("wd_error", bus.ARBITER_ERROR, 1);
        src_q[7].push_back('{data: mk(7, 60, 2), last: 1'b0});
        src_q[7].push_back('{data: mk(7, 60, 3), last: 1'b0});
        src_q[7].push_back('{data: mk(7, 60, 4), last: 1'b1});
        load_frame(0, 61, 2, 1'b1);
        drive();
        run_until_empty("wd_recover", 60);
        check("wd_drained", src_q[7].size(), 0);
        check("wd_error_sticky", bus.ARBITER_ERROR, 1);
`else
        check("no_wd_error", bus.ARBITER_ERROR, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dataframe_stream_arbiter.md
# dataframe_stream_arbiter

Frame-level round-robin arbiter that merges the AXI-Stream outputs of CHANNEL_NUM per-channel dataframe generators onto one AXI-Stream toward the DMA/packer. Grant is held from first beat to TLAST, so frames never interleave. The granted channel index is tagged on M_AXIS_TID. An optional stall watchdog aborts a frame whose source stops mid-frame.

## Interface
- CHANNEL_NUM, 8, number of input streams (2..16)
- TIMEOUT_CYCLES, 1024, watchdog stall limit in ACLK cycles (watchdog build only)
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous, active-low reset
- S_AXIS_TDATA  in  CHANNEL_NUM*`RFDC_TDATA_WIDTH  channel i occupies slice [i*W +: W]
- S_AXIS_TVALID  in  CHANNEL_NUM  per-channel valid
- S_AXIS_TLAST  in  CHANNEL_NUM  per-channel end of frame
- S_AXIS_TREADY  out  CHANNEL_NUM  per-channel ready
- M_AXIS_TDATA  out  `RFDC_TDATA_WIDTH  merged data
- M_AXIS_TVALID  out  1  merged valid
- M_AXIS_TLAST  out  1  merged end of frame
- M_AXIS_TID  out  TID_W = max(1, $clog2(CHANNEL_NUM))  source channel of the current beat
- M_AXIS_TREADY  in  1  downstream ready
- ARBITER_ERROR  out  1  sticky watchdog abort flag (tied 0 without watchdog)

## Operation
- States: IDLE, TRANSFER, plus DRAIN in the watchdog build.
- IDLE: all S_AXIS_TREADY=0, M_AXIS_TVALID=0. If any S_AXIS_TVALID=1, choose the first asserted index scanning upward from (last_grant+1) mod CHANNEL_NUM and wrapping. Register it into grant and go to TRANSFER.
- TRANSFER: combinational pass-through of the granted channel.
  - M_AXIS_TDATA/TVALID/TLAST come from the grant slice.
  - M_AXIS_TID = grant.
  - S_AXIS_TREADY[grant] = M_AXIS_TREADY; every other bit is 0.
- A handshake with TLAST=1 in TRANSFER updates last_grant to grant and returns the FSM to IDLE.
- A channel that keeps TVALID high is never starved. Each other requesting channel is served within CHANNEL_NUM-1 frames.
- TVALID drops mid-frame: grant is held and M_AXIS_TVALID follows the source.
- Single-beat frames (TLAST on the first beat) are legal.
- Reset while in TRANSFER: the FSM goes to IDLE immediately and the partial frame is abandoned downstream. Upstream generators are reset by the same ARESETN.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_grant=CHANNEL_NUM-1 so that channel 0 wins first.
  - All S_AXIS_TREADY=0; M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TID=0, M_AXIS_TDATA=0.
  - ARBITER_ERROR=0, stall counter=0.
- Arbitration latency: request seen in IDLE at cycle n, first beat presented at cycle n+1.
- Frame overhead: one IDLE bubble after each TLAST handshake. Sustained throughput is L/(L+1) for L-beat frames.
- Data path: zero-latency mux, no output register. M_AXIS_TDATA is 0 whenever M_AXIS_TVALID=0.
- Requests that change while in TRANSFER have no effect until the next IDLE.

## Configuration
- Macro: DATAFRAME_ARBITER_WATCHDOG_EN.
- Defined:
  - The 16-bit stall counter runs in TRANSFER. It clears on every handshake and increments on every cycle where the granted TVALID=0.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter emits one forced beat: M_AXIS_TVALID=1, TLAST=1, TDATA=0, TID=grant, held until M_AXIS_TREADY.
  - ARBITER_ERROR is then set (cleared only by reset) and the FSM enters DRAIN.
  - DRAIN: S_AXIS_TREADY[grant]=1 and beats are discarded. Once a TLAST is accepted, last_grant is updated and the FSM returns to IDLE.
- Not defined: no counter, no DRAIN state, ARBITER_ERROR tied 0. A stalled source holds the bus indefinitely.

## Structure
- Shared package `dataframe_arbiter_pkg`:
  - state enum `arb_state_t` (IDLE, TRANSFER, DRAIN).
  - TID width function.
  - `RFDC_TDATA_WIDTH, taken from the existing common defines include.
- Sub-module `rr_priority_picker`: combinational. Inputs are the request vector and last_grant; outputs are the next index and a valid flag. It is reused by later schedulers.
- Everything else (FSM, mux, watchdog) lives in the top module.

## Test plan
- Reset release, all channels idle: all outputs 0. Channel 0 sends a 3-beat frame → M_AXIS_TID=0, 3 beats, TLAST on beat 3, first beat one cycle after TVALID.
- Channels 1, 3 and 5 all assert 4-beat frames together after a channel-0 frame → output order TID 1, 3, 5, with one bubble cycle between frames and no interleaving.
- Channel 2 streams frames continuously while channel 6 requests once → channel 6 is granted immediately after channel 2's current TLAST.
- M_AXIS_TREADY toggles every other cycle during a channel-4 frame of 8 beats → all 8 beats arrive in order, and S_AXIS_TREADY[4] mirrors M_AXIS_TREADY.
- Watchdog build, TIMEOUT_CYCLES=16: channel 7 stops after beat 2 →
  - after 16 stalled cycles, a zero beat with TLAST=1 and TID=7 is output;
  - ARBITER_ERROR=1;
  - the remaining channel-7 beats are dropped up to its TLAST;
  - the next frame from channel 0 is output normally.
- ARESETN asserted mid-frame on channel 3 → all outputs return to reset values in the same cycle; after release, channel 0 has priority.
